// File: rtl/demux_sched_pkg.sv
// rtl/demux_sched_pkg.sv - shared types, constants and digit helper for the demux write scheduler
package demux_sched_pkg;

  localparam int DIGIT_W = 4;

  // Out-of-range select: the demux ignores data while this is driven.
  localparam logic [DIGIT_W-1:0] IDLE_SEL = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    EDIT  = 2'd2
  } state_t;

  // Digit k of a packed 36-bit BCD word lives at bits [4k+3:4k].
  // Indices past the last digit read as zero.
  function automatic logic [DIGIT_W-1:0] digit_of(input logic [35:0] bcd36,
                                                  input logic [3:0]  idx);
    digit_of = '0;
    for (int k = 0; k < 9; k++) begin
      if (idx == 4'(k)) digit_of = bcd36[k*DIGIT_W +: DIGIT_W];
    end
  endfunction

endpackage

// File: rtl/demux_write_sched_if.sv
// rtl/demux_write_sched_if.sv - requester/demux bundle between the scheduler and its clients
interface demux_write_sched_if;
  import demux_sched_pkg::*;

  logic               refresh_req_i;
  logic [35:0]        time_bcd_i;
  logic               refresh_done_o;
  logic               edit_req_i;
  logic [DIGIT_W-1:0] edit_idx_i;
  logic [DIGIT_W-1:0] edit_val_i;
  logic               edit_ack_o;
  logic               edit_err_o;
  logic [DIGIT_W-1:0] sel_o;
  logic [DIGIT_W-1:0] data_o;
  logic               busy_o;

  // Requester side: raises refresh/edit requests and watches the demux bus.
  modport master (
    output refresh_req_i, time_bcd_i, edit_req_i, edit_idx_i, edit_val_i,
    input  refresh_done_o, edit_ack_o, edit_err_o, sel_o, data_o, busy_o
  );

  // Scheduler side.
  modport slave (
    input  refresh_req_i, time_bcd_i, edit_req_i, edit_idx_i, edit_val_i,
    output refresh_done_o, edit_ack_o, edit_err_o, sel_o, data_o, busy_o
  );

endinterface

// File: rtl/demux_write_sched_hold_timer.sv
// rtl/demux_write_sched_hold_timer.sv - hold counter that flags the last cycle of each sel/data hold
module hold_timer #(
  parameter int HOLD_CYCLES = 11111112
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_run,
  output logic o_done
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST_CNT);
  assign o_done = i_run && w_last;

  // Count while a write is on the bus; wrap at the last cycle so consecutive holds chain with no gap.
  always_ff @(posedge clk_i) begin
    if (rst_i || !i_run || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/demux_write_sched.sv
// rtl/demux_write_sched.sv - arbitrates refresh sweeps and single-digit edits onto the BCD demux
module demux_write_sched
  import demux_sched_pkg::*;
#(
  parameter int NUM_DIGITS  = 9,
  parameter int HOLD_CYCLES = 11111112
) (
  input  logic                clk_i,
  input  logic                rst_i,
  demux_write_sched_if.slave  bus
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_DIGITS - 1);
  localparam logic [3:0] NUM_IDX  = 4'(NUM_DIGITS);

  state_t             r_state;
  logic [3:0]         r_idx;
  logic [35:0]        r_snap;
  logic [DIGIT_W-1:0] r_eidx;
  logic [DIGIT_W-1:0] r_eval;
  logic               r_ret;
  logic               r_pend;
  logic               r_rej;

  state_t             w_state_nxt;
  logic [3:0]         w_idx_nxt;
  logic [35:0]        w_snap_nxt;
  logic [DIGIT_W-1:0] w_eidx_nxt;
  logic [DIGIT_W-1:0] w_eval_nxt;
  logic               w_ret_nxt;
  logic               w_pend_nxt;
  logic               w_rej_nxt;

  logic               w_run;
  logic               w_hold_done;
  logic               w_edit_ok;

  assign w_run     = (r_state != IDLE);
  assign w_edit_ok = (bus.edit_idx_i < NUM_IDX);

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_run  (w_run),
    .o_done (w_hold_done)
  );

  // State and context registers; reset abandons any write in flight without ack or done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_snap  <= '0;
      r_eidx  <= '0;
      r_eval  <= '0;
      r_ret   <= 1'b0;
      r_pend  <= 1'b0;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_snap  <= w_snap_nxt;
      r_eidx  <= w_eidx_nxt;
      r_eval  <= w_eval_nxt;
      r_ret   <= w_ret_nxt;
      r_pend  <= w_pend_nxt;
      r_rej   <= w_rej_nxt;
    end
  end

  // Next-state arbitration and demux/handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_snap_nxt  = r_snap;
    w_eidx_nxt  = r_eidx;
    w_eval_nxt  = r_eval;
    w_ret_nxt   = r_ret;
    // A refresh seen while busy is remembered once and served from IDLE.
    w_pend_nxt  = r_pend || ((r_state != IDLE) && bus.refresh_req_i);
    w_rej_nxt   = 1'b0;

    bus.sel_o          = IDLE_SEL;
    bus.data_o         = '0;
    bus.refresh_done_o = 1'b0;
    // An out-of-range edit caught in IDLE is answered one cycle later from r_rej.
    bus.edit_ack_o     = r_rej;
    bus.edit_err_o     = r_rej;
    bus.busy_o         = w_run;

    case (r_state)
      IDLE: begin
        // r_rej masks the request that is being rejected this very cycle.
        if (bus.edit_req_i && !r_rej) begin
          if (w_edit_ok) begin
            w_eidx_nxt  = bus.edit_idx_i;
            w_eval_nxt  = bus.edit_val_i;
            w_ret_nxt   = 1'b0;
            w_state_nxt = EDIT;
          end else begin
            w_rej_nxt = 1'b1;
          end
        end else if (bus.refresh_req_i || r_pend) begin
          w_snap_nxt  = bus.time_bcd_i;
          w_idx_nxt   = '0;
          w_pend_nxt  = 1'b0;
          w_state_nxt = SWEEP;
        end
      end

      SWEEP: begin
        bus.sel_o  = r_idx;
        bus.data_o = digit_of(r_snap, r_idx);
        if (w_hold_done) begin
          // Digit boundary: the only point where an edit may cut in.
          if (bus.edit_req_i && !w_edit_ok) begin
            bus.edit_ack_o = 1'b1;
            bus.edit_err_o = 1'b1;
          end
          if (r_idx == LAST_IDX) begin
            bus.refresh_done_o = 1'b1;
            w_state_nxt        = IDLE;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
            if (bus.edit_req_i && w_edit_ok) begin
              w_eidx_nxt  = bus.edit_idx_i;
              w_eval_nxt  = bus.edit_val_i;
              w_ret_nxt   = 1'b1;
              w_state_nxt = EDIT;
            end
          end
        end
      end

      EDIT: begin
        bus.sel_o  = r_eidx;
        bus.data_o = r_eval;
        if (w_hold_done) begin
          bus.edit_ack_o = 1'b1;
          w_ret_nxt      = 1'b0;
          w_state_nxt    = r_ret ? SWEEP : IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_demux_write_sched.sv
// tb/tb_demux_write_sched.sv - self-checking bench for the demux write scheduler
module tb_demux_write_sched;
  import demux_sched_pkg::*;

  localparam int HOLD = 4;
  localparam int ND   = 9;
  localparam int W    = 48;
  localparam int MAXC = 95;

  typedef struct {
    bit          refresh;
    logic [35:0] bcd;
    bit          has_edit;
    int          r;
    logic [3:0]  idx;
    logic [3:0]  val;
    int          exp_done;
    int          exp_ack;
    int          exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  demux_write_sched_if bus ();

  demux_write_sched #(
    .NUM_DIGITS  (ND),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0] rec_sel  [0:MAXC];
  logic [3:0] rec_data [0:MAXC];
  logic       rec_busy [0:MAXC];
  logic       rec_done [0:MAXC];
  logic       rec_ack  [0:MAXC];
  logic       rec_err  [0:MAXC];
  logic [3:0] exp_sel  [0:MAXC];
  logic [3:0] exp_data [0:MAXC];
  int m_done, m_ack, m_err;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic record(input int c);
    rec_sel[c]  = bus.sel_o;
    rec_data[c] = bus.data_o;
    rec_busy[c] = bus.busy_o;
    rec_done[c] = bus.refresh_done_o;
    rec_ack[c]  = bus.edit_ack_o;
    rec_err[c]  = bus.edit_err_o;
  endtask

  task automatic clear_model();
    for (int c = 0; c <= MAXC; c++) begin
      exp_sel[c]  = IDLE_SEL;
      exp_data[c] = 4'h0;
    end
  endtask

  task automatic put(input int t, input logic [3:0] s, input logic [3:0] d);
    for (int j = 0; j < HOLD; j++) begin
      if (t + j <= MAXC) begin
        exp_sel[t+j]  = s;
        exp_data[t+j] = d;
      end
    end
  endtask

  // Walks the write schedule a demux would see: digits in order, an edit slotted in
  // after the first digit boundary it is visible at, a trailing edit after the sweep.
  task automatic build_model(input vec_t v);
    int t;
    bit served;
    bit ok;
    clear_model();
    m_done = -1;
    m_ack  = -1;
    m_err  = 0;
    ok = (v.idx < ND);
    if (!v.refresh) begin
      if (v.has_edit) begin
        if (ok) begin
          put(1, v.idx, v.val);
          m_ack = HOLD;
        end else begin
          m_ack = 1;
          m_err = 1;
        end
      end
    end else begin
      t = 1;
      served = 0;
      for (int d = 0; d < ND; d++) begin
        put(t, 4'(d), v.bcd[4*d +: 4]);
        t += HOLD;
        if (v.has_edit && !served && v.r <= t - 1) begin
          if (!ok) begin
            m_ack = t - 1;
            m_err = 1;
            served = 1;
          end else if (d < ND - 1) begin
            put(t, v.idx, v.val);
            t += HOLD;
            m_ack = t - 1;
            served = 1;
          end
        end
      end
      m_done = t - 1;
      if (v.has_edit && !served) begin
        put(t + 1, v.idx, v.val);
        m_ack = t + HOLD;
      end
    end
  endtask

  task automatic analyze(input string tag, input int last, input int e_done,
                         input int e_ack, input int e_err);
    int n_mis, f_mis, n_done, f_done, n_ack, f_ack, n_err;
    n_mis = 0; f_mis = -1; n_done = 0; f_done = -1; n_ack = 0; f_ack = -1; n_err = 0;
    for (int c = 1; c <= last; c++) begin
      if (rec_sel[c] !== exp_sel[c] || rec_data[c] !== exp_data[c] ||
          rec_busy[c] !== (exp_sel[c] != IDLE_SEL)) begin
        if (f_mis < 0) f_mis = c;
        n_mis++;
      end
      if (rec_done[c] === 1'b1) begin
        if (f_done < 0) f_done = c;
        n_done++;
      end
      if (rec_ack[c] === 1'b1) begin
        if (f_ack < 0) f_ack = c;
        n_ack++;
      end
      if (rec_err[c] === 1'b1) n_err++;
    end
    check({tag, " stream_bad_cycles"}, n_mis, 0);
    if (f_mis >= 0)
      $display("  %s first diff cycle %0d: sel=%h data=%h busy=%b want sel=%h data=%h",
               tag, f_mis, rec_sel[f_mis], rec_data[f_mis], rec_busy[f_mis],
               exp_sel[f_mis], exp_data[f_mis]);
    check({tag, " done_cycle"}, f_done, e_done);
    check({tag, " done_count"}, n_done, (e_done < 0) ? 0 : 1);
    check({tag, " ack_cycle"}, f_ack, e_ack);
    check({tag, " ack_count"}, n_ack, (e_ack < 0) ? 0 : 1);
    check({tag, " err_count"}, n_err, e_err);
  endtask

  // Cycle 0 is the negedge where requests go up; cycle c is sampled at the c-th negedge after.
  task automatic run_vec(input vec_t v);
    bit served;
    @(negedge clk);
    bus.time_bcd_i    = v.bcd;
    bus.refresh_req_i = v.refresh;
    bus.edit_idx_i    = v.idx;
    bus.edit_val_i    = v.val;
    bus.edit_req_i    = v.has_edit && (v.r == 0);
    served = 0;
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      record(c);
      bus.refresh_req_i = 1'b0;
      if (bus.edit_req_i && bus.edit_ack_o === 1'b1) begin
        bus.edit_req_i = 1'b0;
        served = 1;
      end else if (v.has_edit && !served && c == v.r) begin
        bus.edit_req_i = 1'b1;
      end
    end
    bus.edit_req_i = 1'b0;
  endtask

  vec_t tbl [7];
  vec_t rv;
  int   n_wr;

  initial begin
    tbl[0] = '{1'b1, 36'h123456789, 1'b0, 0,  4'd0,  4'd0, 36, -1, 0};
    tbl[1] = '{1'b0, 36'h0,         1'b1, 0,  4'd3,  4'd7, -1,  4, 0};
    tbl[2] = '{1'b1, 36'h123456789, 1'b1, 9,  4'd4,  4'd5, 40, 16, 0};
    tbl[3] = '{1'b0, 36'h0,         1'b1, 0,  4'd12, 4'd3, -1,  1, 1};
    tbl[4] = '{1'b1, 36'h987654321, 1'b1, 5,  4'd9,  4'd1, 36,  8, 1};
    tbl[5] = '{1'b1, 36'h090807060, 1'b1, 34, 4'd0,  4'd9, 36, 41, 0};
    tbl[6] = '{1'b1, 36'h999999999, 1'b1, 1,  4'd8,  4'd0, 40,  8, 0};

    rst = 1'b1;
    bus.refresh_req_i = 1'b0;
    bus.time_bcd_i    = '0;
    bus.edit_req_i    = 1'b0;
    bus.edit_idx_i    = '0;
    bus.edit_val_i    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: parked select, no writes, no pulses.
    n_wr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("idle[%0d] sel,data,busy,done,ack,err", c),
            int'({bus.sel_o, bus.data_o, bus.busy_o, bus.refresh_done_o,
                  bus.edit_ack_o, bus.edit_err_o}),
            int'({IDLE_SEL, 4'h0, 4'h0}));
      if (bus.sel_o < ND) n_wr++;
    end
    check("idle demux writes", n_wr, 0);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      build_model(tbl[i]);
      run_vec(tbl[i]);
      analyze($sformatf("vec%0d", i), W, tbl[i].exp_done, tbl[i].exp_ack, tbl[i].exp_err);
    end

    // Randomized scenarios against the schedule model.
    for (int i = 0; i < 30; i++) begin
      rv.refresh  = ($urandom_range(0, 3) != 0);
      for (int d = 0; d < ND; d++) rv.bcd[4*d +: 4] = 4'($urandom_range(0, 9));
      rv.has_edit = ($urandom_range(0, 3) != 0);
      rv.idx      = 4'($urandom_range(0, 15));
      rv.val      = 4'($urandom_range(0, 9));
      if (rv.refresh) begin
        rv.r = $urandom_range(1, 35);
        if (rv.r % 4 == 0) rv.r = rv.r - 1;
      end else begin
        rv.r = 0;
      end
      build_model(rv);
      run_vec(rv);
      analyze($sformatf("rnd%0d", i), W, m_done, m_ack, m_err);
    end

    // Queued refresh with a new snapshot, then reset in the middle of the second sweep.
    clear_model();
    for (int d = 0; d < ND; d++) put(1 + 4*d, 4'(d), 4'(d + 1));
    for (int d = 0; d < ND; d++) put(38 + 4*d, 4'(d), 4'(8 - d));
    for (int c = 51; c <= MAXC; c++) begin
      exp_sel[c]  = IDLE_SEL;
      exp_data[c] = 4'h0;
    end
    @(negedge clk);
    bus.time_bcd_i    = 36'h987654321;
    bus.refresh_req_i = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      record(c);
      bus.refresh_req_i = 1'b0;
      if (c == 10) begin
        bus.time_bcd_i    = 36'h012345678;
        bus.refresh_req_i = 1'b1;
      end
      if (c == 50) rst = 1'b1;
      if (c == 51) rst = 1'b0;
    end
    analyze("pend_reset", 80, 36, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
